bsr_index_walker: RTL and testbench

- Upstream feeder for the block-sparse AV multiply stage.
- Walks a BSR structure (row_ptr / col_idx SRAMs) for one attention head.
- Emits one (block_row, block_col) descriptor per nonzero block on a valid/ready stream consumed by the spmm stage.
- Uses the same start/busy/done control handshake as the rest of the sparse-attention pipeline.

---
 rtl/bsr_index_walker.sv | 175 +++++++++++++++++
 tb/tb_bsr_index_walker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bsr_index_walker.sv
// Walks row_ptr/col_idx of one BSR head and emits one (block_row, block_col) descriptor per nonzero block.
// Latency: start to first out_valid is 4 cycles when row 0 is nonempty; at most 1 descriptor per 2 cycles; empty rows cost 1 cycle.
// Backpressure: out_valid and out_* hold in EMIT until out_ready; no combinational path from out_ready to out_valid.
module bsr_index_walker #(
  parameter int IDX_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] m_block_rows,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] blocks_total,
  output logic             rp_rd_en,
  output logic [IDX_W-1:0] rp_addr,
  input  logic [IDX_W-1:0] rp_rdata,
  output logic             ci_rd_en,
  output logic [IDX_W-1:0] ci_addr,
  input  logic [IDX_W-1:0] ci_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_block_row,
  output logic [IDX_W-1:0] out_block_col,
  output logic             out_row_last
);

  typedef enum logic [2:0] {IDLE, RP_LO, RP_HI, CI_WAIT, EMIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] m_lat, row, k, ptr_lo, ptr_hi;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] row_inc, row_inc2, k_inc;

  // Index increments kept at IDX_W so comparisons wrap the same way the hardware does.
  assign row_inc  = row + 1'b1;
  assign row_inc2 = row + 2'd2;
  assign k_inc    = k + 1'b1;

  assign busy = (state != IDLE) && (state != DONE);

  // Next-state and SRAM read issue; reads are combinational so data lands in the following state.
  always_comb begin
    state_nxt = state;
    rp_rd_en  = 1'b0;
    rp_addr   = '0;
    ci_rd_en  = 1'b0;
    ci_addr   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (m_block_rows == '0) begin
            state_nxt = DONE;
          end else begin
            rp_rd_en  = 1'b1;
            rp_addr   = '0;
            state_nxt = RP_LO;
          end
        end
      end
      RP_LO: begin
        rp_rd_en  = 1'b1;
        rp_addr   = row_inc;
        state_nxt = RP_HI;
      end
      RP_HI: begin
        if (rp_rdata <= ptr_lo) begin
          if (row_inc == m_lat) begin
            state_nxt = DONE;
          end else begin
            rp_rd_en = 1'b1;
            rp_addr  = row_inc2;
          end
        end else begin
          ci_rd_en  = 1'b1;
          ci_addr   = ptr_lo;
          state_nxt = CI_WAIT;
        end
      end
      CI_WAIT: state_nxt = EMIT;
      EMIT: begin
        if (out_ready) begin
          if (k_inc < ptr_hi) begin
            ci_rd_en  = 1'b1;
            ci_addr   = k_inc;
            state_nxt = CI_WAIT;
          end else if (row_inc == m_lat) begin
            state_nxt = DONE;
          end else begin
            rp_rd_en  = 1'b1;
            rp_addr   = row_inc2;
            state_nxt = RP_HI;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // No reads escape while the block is being reset.
    if (rst) begin
      rp_rd_en = 1'b0;
      rp_addr  = '0;
      ci_rd_en = 1'b0;
      ci_addr  = '0;
    end
  end

  // State register plus walk datapath: pointers, counters, error flag and the output descriptor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      m_lat         <= '0;
      row           <= '0;
      k             <= '0;
      ptr_lo        <= '0;
      ptr_hi        <= '0;
      cnt           <= '0;
      err           <= 1'b0;
      done          <= 1'b0;
      blocks_total  <= '0;
      out_valid     <= 1'b0;
      out_block_row <= '0;
      out_block_col <= '0;
      out_row_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            m_lat <= m_block_rows;
            row   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        RP_LO: ptr_lo <= rp_rdata;
        RP_HI: begin
          ptr_hi <= rp_rdata;
          if (rp_rdata <= ptr_lo) begin
            if (rp_rdata < ptr_lo) err <= 1'b1;
            if (row_inc != m_lat) begin
              row    <= row_inc;
              ptr_lo <= rp_rdata;
            end
          end else begin
            k <= ptr_lo;
          end
        end
        CI_WAIT: begin
          out_block_col <= ci_rdata;
          out_block_row <= row;
          out_row_last  <= (k_inc == ptr_hi);
          out_valid     <= 1'b1;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= cnt + 1'b1;
            if (k_inc < ptr_hi) begin
              k <= k_inc;
            end else if (row_inc != m_lat) begin
              row    <= row_inc;
              ptr_lo <= ptr_hi;
            end
          end
        end
        DONE: blocks_total <= cnt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bsr_index_walker.sv
module tb_bsr_index_walker;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, err;
  logic [15:0] m_block_rows;
  logic [31:0] blocks_total;
  logic        rp_rd_en, ci_rd_en;
  logic [15:0] rp_addr, rp_rdata, ci_addr, ci_rdata;
  logic        out_valid, out_ready, out_row_last;
  logic [15:0] out_block_row, out_block_col;

  logic [15:0] rp_mem [0:15];
  logic [15:0] ci_mem [0:15];

  int n_vec  = 0;
  int n_miss = 0;
  int done_cnt = 0, rp_reads = 0, ci_reads = 0;
  int bp_mode = 0, wait_cnt = 0;
  logic [32:0] sb[$];
  logic        hold = 1'b0;
  logic [32:0] hold_dat;

  always #5 clk = ~clk;

  bsr_index_walker #(.IDX_W(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .m_block_rows(m_block_rows),
    .busy(busy), .done(done), .err(err), .blocks_total(blocks_total),
    .rp_rd_en(rp_rd_en), .rp_addr(rp_addr), .rp_rdata(rp_rdata),
    .ci_rd_en(ci_rd_en), .ci_addr(ci_addr), .ci_rdata(ci_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_block_row(out_block_row), .out_block_col(out_block_col),
    .out_row_last(out_row_last)
  );

  // Synchronous-read SRAM models: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rp_rd_en) rp_rdata <= rp_mem[rp_addr[3:0]];
    if (ci_rd_en) ci_rdata <= ci_mem[ci_addr[3:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pops on handshake, stability while stalled, event counters.
  always @(negedge clk) begin
    logic [32:0] cur;
    cur = {out_block_row, out_block_col, out_row_last};
    if (rp_rd_en) rp_reads++;
    if (ci_rd_en) ci_reads++;
    if (done) done_cnt++;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_dat", {31'd0, cur}, {31'd0, hold_dat});
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) check("desc", {31'd0, cur}, {31'd0, sb.pop_front()});
      end
      hold     = out_valid && !out_ready;
      hold_dat = cur;
    end
  end

  // Consumer: always ready, or ready only on the third cycle of each descriptor.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode == 0) begin
        out_ready = 1'b1;
      end else if (!out_valid) begin
        out_ready = 1'b0;
        wait_cnt  = 0;
      end else if (wait_cnt == 2) begin
        out_ready = 1'b1;
        wait_cnt  = 0;
      end else begin
        out_ready = 1'b0;
        wait_cnt++;
      end
    end
  end

  task automatic load_test1();
    rp_mem[0] = 16'd0; rp_mem[1] = 16'd2; rp_mem[2] = 16'd3;
    ci_mem[0] = 16'd1; ci_mem[1] = 16'd3; ci_mem[2] = 16'd0;
    sb.push_back({16'd0, 16'd1, 1'b0});
    sb.push_back({16'd0, 16'd3, 1'b1});
    sb.push_back({16'd1, 16'd0, 1'b1});
  endtask

  // Pulses start (and optionally a stray start at ign_cyc), waits for done and checks the outcome.
  task automatic run_walk(input logic [15:0] m, input int ign_cyc, input logic exp_err,
                          input logic [31:0] exp_total, input int exp_first, input int exp_done_cyc);
    int cyc, first, d0;
    d0 = done_cnt; first = -1; cyc = 0;
    m_block_rows = m;
    start = 1'b1;
    do begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == ign_cyc);
      if (out_valid && first < 0) first = cyc;
    end while (!done && cyc < 2000);
    start = 1'b0;
    check("done_seen", {63'd0, done}, 64'd1);
    if (exp_done_cyc >= 0) check("done_lat", 64'(cyc), 64'(exp_done_cyc));
    if (exp_first >= 0) check("first_lat", 64'(first), 64'(exp_first));
    check("blocks_total", {32'd0, blocks_total}, {32'd0, exp_total});
    check("err", {63'd0, err}, {63'd0, exp_err});
    check("sb_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
    check("done_pulse", {63'd0, done}, 64'd0);
    check("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_err"}, {63'd0, err}, 64'd0);
    check({tag, "_total"}, {32'd0, blocks_total}, 64'd0);
    check({tag, "_strobes"}, {62'd0, rp_rd_en, ci_rd_en}, 64'd0);
    check({tag, "_addrs"}, {32'd0, rp_addr, ci_addr}, 64'd0);
    check({tag, "_out"}, {29'd0, out_valid, out_block_row, out_block_col, out_row_last}, 64'd0);
  endtask

  initial begin
    int r0, c0, d0, cyc;
    for (int i = 0; i < 16; i++) begin rp_mem[i] = '0; ci_mem[i] = '0; end
    rst = 1'b1; start = 1'b0; m_block_rows = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: basic walk
    load_test1();
    run_walk(16'd2, -1, 1'b0, 32'd3, 4, 11);

    // Test 2: empty rows
    rp_mem[0] = 0; rp_mem[1] = 0; rp_mem[2] = 1; rp_mem[3] = 1; rp_mem[4] = 1;
    ci_mem[0] = 16'd5;
    sb.push_back({16'd1, 16'd5, 1'b1});
    run_walk(16'd4, -1, 1'b0, 32'd1, 5, 9);

    // Test 3: backpressure
    bp_mode = 1;
    load_test1();
    run_walk(16'd2, -1, 1'b0, 32'd3, 4, -1);
    bp_mode = 0;

    // Test 4: zero rows, then malformed row_ptr
    r0 = rp_reads; c0 = ci_reads;
    run_walk(16'd0, -1, 1'b0, 32'd0, -1, 2);
    check("m0_reads", 64'(rp_reads - r0 + ci_reads - c0), 64'd0);
    rp_mem[0] = 16'd3; rp_mem[1] = 16'd1;
    run_walk(16'd1, -1, 1'b1, 32'd0, -1, 4);

    // Test 5: reset while stalled in EMIT, then a fresh run
    bp_mode = 1;
    load_test1();
    m_block_rows = 16'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    check("rst_reached_emit", {63'd0, out_valid}, 64'd1);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    repeat (15) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    bp_mode = 0;
    load_test1();
    run_walk(16'd2, -1, 1'b0, 32'd3, 4, 11);

    // Test 6: stray start while busy
    load_test1();
    run_walk(16'd2, 6, 1'b0, 32'd3, 4, 11);
    repeat (5) @(posedge clk);
    #1;
    check("stray_start_idle", {63'd0, busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
